// File: rtl/avr_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avr_lsu_pkg
//  Description : Shared types and constants for the AVR load/store unit:
//                FSM state encoding, pointer addressing-mode codes and the
//                data-path widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package avr_lsu_pkg;

    localparam int DADDR_W = 16;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PM_PLAIN   = 2'b00,
        PM_POSTINC = 2'b01,
        PM_PREDEC  = 2'b10,
        PM_DISP    = 2'b11
    } ptr_mode_t;

endpackage
`default_nettype wire

// File: rtl/avr_lsu_agen.sv
`default_nettype none
// ============================================================================
//  Module      : avr_lsu_agen
//  Description : Combinational address generator. Maps the pointer value,
//                addressing mode and displacement to the byte address, the
//                updated pointer value and a flag saying whether the pointer
//                pair must be written back. All arithmetic wraps modulo 2^16.
//  Ports       : i_ptr      - current X/Y/Z pointer
//                i_mode     - addressing mode (ptr_mode_t code)
//                i_disp     - q displacement, zero-extended
//                o_addr     - data-memory byte address
//                o_ptr_next - pointer value to write back
//                o_ptr_upd  - pointer write-back required
//  Revision    : 1.0 - initial release
// ============================================================================
module avr_lsu_agen
    import avr_lsu_pkg::*;
(
    input  logic [DADDR_W-1:0] i_ptr,
    input  logic [1:0]         i_mode,
    input  logic [5:0]         i_disp,
    output logic [DADDR_W-1:0] o_addr,
    output logic [DADDR_W-1:0] o_ptr_next,
    output logic               o_ptr_upd
);

    logic [DADDR_W-1:0] w_ptr_inc;
    logic [DADDR_W-1:0] w_ptr_dec;
    logic [DADDR_W-1:0] w_ptr_disp;

    assign w_ptr_inc  = i_ptr + 16'd1;
    assign w_ptr_dec  = i_ptr - 16'd1;
    assign w_ptr_disp = i_ptr + {10'd0, i_disp};

    always_comb begin
        o_addr     = i_ptr;
        o_ptr_next = i_ptr;
        o_ptr_upd  = 1'b0;
        case (i_mode)
            PM_POSTINC: begin
                o_ptr_next = w_ptr_inc;
                o_ptr_upd  = 1'b1;
            end
            PM_PREDEC: begin
                // Pre-decrement uses the decremented value for both the
                // access and the write-back.
                o_addr     = w_ptr_dec;
                o_ptr_next = w_ptr_dec;
                o_ptr_upd  = 1'b1;
            end
            PM_DISP: begin
                o_addr = w_ptr_disp;
            end
            default: begin
                o_addr = i_ptr;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/avr_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : avr_lsu
//  Description : Load/store unit for LD/ST/LDD/STD through X/Y/Z. Captures a
//                request from the decoder, runs the data-memory req/ack
//                handshake with a bounded wait, then pulses load data,
//                pointer write-back or a timeout error for one cycle.
//  Ports       : CLK, RST           - clock, synchronous active-high reset
//                start, op_store, ptr_mode, ptr_in, disp, st_data
//                                   - request from the decoder
//                busy               - combinational PC stall request
//                mem_req/we/addr/wdata, mem_rdata, mem_ack
//                                   - data-memory handshake
//                ld_valid, ld_data  - load result for Rd
//                ptr_we, ptr_out    - pointer pair write-back
//                err                - access timed out
//  Revision    : 1.0 - initial release
// ============================================================================
module avr_lsu
    import avr_lsu_pkg::*;
#(
    parameter int TIMEOUT = 15
)(
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                op_store,
    input  logic [1:0]          ptr_mode,
    input  logic [DADDR_W-1:0]  ptr_in,
    input  logic [5:0]          disp,
    input  logic [DATA_W-1:0]   st_data,
    output logic                busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                ld_valid,
    output logic [DATA_W-1:0]   ld_data,
    output logic                ptr_we,
    output logic [DADDR_W-1:0]  ptr_out,
    output logic                err
);

    // Last wait count before the access is abandoned.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic [7:0]          r_wait;
    logic                r_store;
    logic                r_upd;
    logic [DADDR_W-1:0]  r_ptr_next;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [DADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_ld_valid;
    logic [DATA_W-1:0]   r_ld_data;
    logic                r_ptr_we;
    logic [DADDR_W-1:0]  r_ptr_out;
    logic                r_err;

    logic [DADDR_W-1:0]  w_addr;
    logic [DADDR_W-1:0]  w_ptr_next;
    logic                w_ptr_upd;

    avr_lsu_agen u_agen (
        .i_ptr      (ptr_in),
        .i_mode     (ptr_mode),
        .i_disp     (disp),
        .o_addr     (w_addr),
        .o_ptr_next (w_ptr_next),
        .o_ptr_upd  (w_ptr_upd)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_wait      <= 8'd0;
            r_store     <= 1'b0;
            r_upd       <= 1'b0;
            r_ptr_next  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ld_valid  <= 1'b0;
            r_ld_data   <= '0;
            r_ptr_we    <= 1'b0;
            r_ptr_out   <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= REQ;
                        r_wait      <= 8'd0;
                        r_store     <= op_store;
                        r_upd       <= w_ptr_upd;
                        r_ptr_next  <= w_ptr_next;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= op_store;
                        r_mem_addr  <= w_addr;
                        r_mem_wdata <= st_data;
                    end
                end
                REQ: begin
                    // Acknowledge is checked first so it wins over a
                    // timeout landing in the same cycle.
                    if (mem_ack) begin
                        r_state    <= DONE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_ld_valid <= ~r_store;
                        if (!r_store) begin
                            r_ld_data <= mem_rdata;
                        end
                        r_ptr_we <= r_upd;
                        if (r_upd) begin
                            r_ptr_out <= r_ptr_next;
                        end
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_ld_valid <= 1'b0;
                    r_ptr_we   <= 1'b0;
                    r_err      <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Combinational so the core holds PC already in the issue cycle.
    assign busy      = start | (r_state != IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ld_valid  = r_ld_valid;
    assign ld_data   = r_ld_data;
    assign ptr_we    = r_ptr_we;
    assign ptr_out   = r_ptr_out;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_avr_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_lsu
//  Description : Scoreboard testbench for avr_lsu (TIMEOUT = 4). Stimulus
//                pushes expected memory requests, completion pulses and busy
//                lengths into queues; independent monitors pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_lsu;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        int          len;
    } req_t;

    typedef struct packed {
        logic        ldv;
        logic [7:0]  ldd;
        logic        pwe;
        logic [15:0] pout;
        logic        err;
    } done_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        op_store = 1'b0;
    logic [1:0]  ptr_mode = 2'b00;
    logic [15:0] ptr_in = 16'h0000;
    logic [5:0]  disp = 6'd0;
    logic [7:0]  st_data = 8'h00;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ptr_we;
    logic [15:0] ptr_out;
    logic        err;

    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [7:0]  resp_rdata = 8'hEE;
    int          cfg_wait = 0;
    logic [7:0]  cfg_rdata = 8'h00;

    int n_checks = 0;
    int n_err = 0;

    req_t  req_q[$];
    done_t done_q[$];
    int    busy_q[$];

    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = resp_rdata;

    avr_lsu #(.TIMEOUT(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .op_store  (op_store),
        .ptr_mode  (ptr_mode),
        .ptr_in    (ptr_in),
        .disp      (disp),
        .st_data   (st_data),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ptr_we    (ptr_we),
        .ptr_out   (ptr_out),
        .err       (err)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_ld_valid"},  32'(ld_valid),  32'd0);
        chk({tag, "_ld_data"},   32'(ld_data),   32'd0);
        chk({tag, "_ptr_we"},    32'(ptr_we),    32'd0);
        chk({tag, "_ptr_out"},   32'(ptr_out),   32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
    endtask

    // Memory model: acknowledges after cfg_wait wait states (never if < 0);
    // read data is only meaningful in the acknowledge cycle.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge CLK);
            if (mem_req === 1'b1) begin
                if (cnt == cfg_wait) begin
                    resp_ack   = 1'b1;
                    resp_rdata = cfg_rdata;
                end else begin
                    resp_ack   = 1'b0;
                    resp_rdata = 8'hEE;
                end
                cnt++;
            end else begin
                resp_ack   = 1'b0;
                resp_rdata = 8'hEE;
                cnt        = 0;
            end
        end
    end

    // Request monitor: fields at the first request cycle, stability while
    // held, and the number of cycles the request stays high.
    initial begin
        logic prev;
        logic has_cur;
        int   len;
        req_t cur;
        prev = 1'b0; has_cur = 1'b0; len = 0; cur = '0;
        forever begin
            @(negedge CLK);
            if (mem_req === 1'b1 && !prev) begin
                chk("req_expected", 32'(req_q.size() != 0), 32'd1);
                has_cur = (req_q.size() != 0);
                if (has_cur) begin
                    cur = req_q.pop_front();
                    chk("req_addr", 32'(mem_addr), 32'(cur.addr));
                    chk("req_we",   32'(mem_we),   32'(cur.we));
                    if (cur.we) chk("req_wdata", 32'(mem_wdata), 32'(cur.wdata));
                end
                len = 1;
            end else if (mem_req === 1'b1) begin
                len++;
                if (has_cur) chk("req_addr_hold", 32'(mem_addr), 32'(cur.addr));
            end else if (prev && has_cur) begin
                chk("req_len", 32'(len), 32'(cur.len));
                has_cur = 1'b0;
            end
            prev = (mem_req === 1'b1);
        end
    end

    // Completion monitor: any pulse must match the next expected completion.
    initial begin
        done_t e;
        forever begin
            @(negedge CLK);
            if ((ld_valid | ptr_we | err) === 1'b1) begin
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    chk("ld_valid", 32'(ld_valid), 32'(e.ldv));
                    if (e.ldv) chk("ld_data", 32'(ld_data), 32'(e.ldd));
                    chk("ptr_we", 32'(ptr_we), 32'(e.pwe));
                    if (e.pwe) chk("ptr_out", 32'(ptr_out), 32'(e.pout));
                    chk("err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    // Busy monitor: length of each contiguous busy period.
    initial begin
        int len;
        len = 0;
        forever begin
            @(negedge CLK);
            if (busy === 1'b1) begin
                len++;
            end else if (len != 0) begin
                chk("busy_expected", 32'(busy_q.size() != 0), 32'd1);
                if (busy_q.size() != 0) chk("busy_len", 32'(len), 32'(busy_q.pop_front()));
                len = 0;
            end
        end
    end

    task automatic run_access(
        input logic        st,
        input logic [1:0]  md,
        input logic [15:0] p,
        input logic [5:0]  d,
        input logic [7:0]  wd,
        input int          wt,
        input logic [7:0]  rd,
        input logic [15:0] e_addr,
        input int          e_len,
        input logic        e_ldv,
        input logic        e_pwe,
        input logic [15:0] e_pout,
        input logic        e_err,
        input logic        poke
    );
        logic fin;
        req_q.push_back('{addr: e_addr, we: st, wdata: wd, len: e_len});
        if (e_ldv | e_pwe | e_err)
            done_q.push_back('{ldv: e_ldv, ldd: rd, pwe: e_pwe, pout: e_pout, err: e_err});
        busy_q.push_back(e_len + 2);
        cfg_wait  = wt;
        cfg_rdata = rd;
        @(posedge CLK); #1;
        start = 1'b1; op_store = st; ptr_mode = md; ptr_in = p; disp = d; st_data = wd;
        @(posedge CLK); #1;
        start = 1'b0; ptr_in = 16'hDEAD; disp = 6'd0; st_data = 8'h00;
        if (poke) begin
            @(posedge CLK); #1;
            start = 1'b1; op_store = ~st; ptr_mode = 2'b11; ptr_in = 16'h1234; disp = 6'd7;
            @(posedge CLK); #1;
            start = 1'b0;
        end
        fin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (busy === 1'b0) begin
                fin = 1'b1;
                break;
            end
        end
        chk("access_completes", 32'(fin), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // Load, post-increment, zero wait.
        run_access(1'b0, 2'b01, 16'h0100, 6'd0, 8'h00, 0, 8'hA5,
                   16'h0100, 1, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0);
        // Store, pre-decrement at 0x0000, two wait states.
        run_access(1'b1, 2'b10, 16'h0000, 6'd0, 8'h3C, 2, 8'h00,
                   16'hFFFF, 3, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        // LDD, displacement wraps past 0xFFFF.
        run_access(1'b0, 2'b11, 16'hFFF0, 6'd63, 8'h00, 1, 8'h5A,
                   16'h002F, 2, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        // Timeout: no acknowledge at all.
        run_access(1'b0, 2'b00, 16'h2000, 6'd0, 8'h00, -1, 8'h00,
                   16'h2000, 4, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Acknowledge in the last allowed cycle wins over the timeout.
        run_access(1'b0, 2'b00, 16'h2001, 6'd0, 8'h00, 3, 8'h77,
                   16'h2001, 4, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        // Post-increment store at 0xFFFF wraps pointer to 0x0000.
        run_access(1'b1, 2'b01, 16'hFFFF, 6'd0, 8'h81, 0, 8'h00,
                   16'hFFFF, 1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);

        // Stray acknowledge while idle must do nothing.
        @(posedge CLK); #1;
        stray_ack = 1'b1;
        @(posedge CLK); #1;
        stray_ack = 1'b0;
        repeat (2) @(posedge CLK);

        // Second start pulsed during REQ is ignored.
        run_access(1'b0, 2'b10, 16'h0010, 6'd0, 8'h00, 2, 8'h11,
                   16'h000F, 3, 1'b1, 1'b1, 16'h000F, 1'b0, 1'b1);

        // Reset in the middle of a request kills it silently.
        req_q.push_back('{addr: 16'h0050, we: 1'b0, wdata: 8'h00, len: 2});
        busy_q.push_back(3);
        cfg_wait = -1;
        @(posedge CLK); #1;
        start = 1'b1; op_store = 1'b0; ptr_mode = 2'b00; ptr_in = 16'h0050; disp = 6'd0;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk_zero("midreset");

        // Fresh access after the reset.
        run_access(1'b0, 2'b00, 16'h0042, 6'd0, 8'h00, 0, 8'hC3,
                   16'h0042, 1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        // STD with displacement: no pulses expected.
        run_access(1'b1, 2'b11, 16'h1000, 6'd5, 8'h99, 1, 8'h00,
                   16'h1005, 2, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        repeat (5) @(posedge CLK);
        chk("req_q_drained",  32'(req_q.size()),  32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        chk("busy_q_drained", 32'(busy_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/avr_lsu.md
# avr_lsu

Load/store unit for the AVR core, directly downstream of the instruction decoder. It executes LD/ST/LDD/STD through the X/Y/Z pointers with direct, post-increment, pre-decrement and displacement addressing, which the decoder does not implement. It drives the data-memory request/acknowledge handshake, returns load data and updated pointer values for register-file writeback, and asserts `busy` so the core holds PC (pc_select = 001) until the access retires.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum number of cycles `mem_req` waits for `mem_ack` before the access is aborted. Legal range 1..255.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset: synchronous, active-high.
- `start`  in  1  decoder issues a memory op. Accepted only while the FSM is in IDLE.
- `op_store`  in  1  1 = store, 0 = load. Sampled with `start`.
- `ptr_mode`  in  2  00 = plain, 01 = post-increment, 10 = pre-decrement, 11 = displacement. Sampled with `start`.
- `ptr_in`  in  16  current X/Y/Z value. Sampled with `start`.
- `disp`  in  6  q displacement, zero-extended. Sampled with `start`.
- `st_data`  in  8  Rr value for a store. Sampled with `start`.
- `busy`  out  1  stall request to the core's PC control.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  write enable, valid while `mem_req` is high.
- `mem_addr`  out  16  byte address.
- `mem_wdata`  out  8  store data.
- `mem_rdata`  in  8  load data, valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  memory completes the request.
- `ld_valid`  out  1  one-cycle pulse; `ld_data` is to be written to Rd.
- `ld_data`  out  8  registered load data.
- `ptr_we`  out  1  one-cycle pulse; `ptr_out` is to be written to the pointer pair.
- `ptr_out`  out  16  updated pointer value.
- `err`  out  1  one-cycle pulse; the access timed out.

## Operation
- States:
  - IDLE → REQ on `start`.
  - REQ → DONE on `mem_ack` or on timeout.
  - DONE → IDLE unconditionally.
- On `start`, the unit registers all request fields and the generated address.
- Address and pointer update, all modulo 2^16:
  - plain: addr = ptr; no pointer update.
  - post-increment: addr = ptr; ptr_out = ptr + 1.
  - pre-decrement: addr = ptr − 1; ptr_out = ptr − 1.
  - displacement: addr = ptr + disp; no pointer update.
- Wrap-around: post-increment at 0xFFFF gives ptr_out = 0x0000. Pre-decrement at 0x0000 gives addr = ptr_out = 0xFFFF.
- REQ:
  - `mem_req` = 1; `mem_addr`, `mem_we` and `mem_wdata` are held stable.
  - A wait counter clears on entry and increments each cycle that `mem_ack` is 0.
  - On `mem_ack`, `mem_rdata` is latched for a load.
  - If the count reaches TIMEOUT − 1 and `mem_ack` is still 0, the access is aborted.
  - When `mem_ack` and timeout coincide, `mem_ack` wins.
- DONE, successful load: `ld_valid` = 1. `ptr_we` = 1 if the mode updates the pointer.
- DONE, successful store: `ld_valid` = 0. `ptr_we` follows the same rule as for a load.
- DONE, aborted access: `err` = 1; `ld_valid` = 0 and `ptr_we` = 0, so the pointer is unchanged.
- `busy` = `start` | (state ≠ IDLE). This is combinational, so the core stalls in the issue cycle.
- `start` is ignored outside IDLE.
- `mem_ack` is ignored outside REQ.

## Timing
- Reset:
  - state = IDLE, wait counter = 0.
  - `mem_req`, `mem_we`, `ld_valid`, `ptr_we`, `err` = 0.
  - `mem_addr`, `mem_wdata`, `ld_data`, `ptr_out` = 0.
- `busy` = 0 in reset, provided `start` is low.
- RST mid-operation: the FSM is in IDLE and all of the above values hold at the next edge. No pulses are emitted for the killed access.
- Zero-wait access:
  - `start` in cycle 0.
  - `mem_req` in cycle 1, with `mem_ack` = 1 in the same cycle.
  - DONE pulses in cycle 2.
  - `busy` is high in cycles 0–2 (3 cycles).
- Each wait state adds one cycle.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then `err` pulses in the following cycle.
- `start` may be reasserted in the cycle after DONE.
- All outputs except `busy` are registered.

## Structure
- Package `avr_lsu_pkg` holds:
  - the state enum (IDLE, REQ, DONE);
  - the `ptr_mode` codes (PM_PLAIN, PM_POSTINC, PM_PREDEC, PM_DISP);
  - the width constants DADDR_W = 16 and DATA_W = 8.
- One natural sub-module: `avr_lsu_agen`, a combinational block mapping {ptr, mode, disp} to {addr, ptr_next, ptr_upd}.
- The FSM, wait counter and output registers live in `avr_lsu`.

## Test plan
- Load, post-increment, zero-wait: ptr = 0x0100, `mem_rdata` = 0xA5 → `mem_addr` = 0x0100; in cycle 2, `ld_valid` with `ld_data` = 0xA5, and `ptr_we` with `ptr_out` = 0x0101; `busy` high in cycles 0–2.
- Store, pre-decrement, 2 wait states: ptr = 0x0000, `st_data` = 0x3C → `mem_addr` = 0xFFFF, `mem_we` = 1, `mem_wdata` = 0x3C; `mem_req` high 3 cycles; `ptr_out` = 0xFFFF; `ld_valid` = 0.
- LDD displacement: ptr = 0xFFF0, disp = 63 → `mem_addr` = 0x002F; `ptr_we` = 0.
- Timeout with TIMEOUT = 4 and `mem_ack` never high → `mem_req` high 4 cycles, then `err` pulses for 1 cycle; no `ld_valid` or `ptr_we`; IDLE next. Repeat with `mem_ack` arriving in the 4th cycle → normal completion and no `err`.
- `start` pulsed while in REQ, plus a stray `mem_ack` in IDLE → both ignored; exactly one access performed.
- RST asserted while in REQ → IDLE with all outputs zero at the next edge; no pulses; a fresh `start` afterwards completes normally.
